// File: rtl/host_if_pkg.sv
// Shared types and address-decode helpers for the host line responder.
// The decode helpers work on a 64-bit zero-extended byte address.
package host_if_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RD_RDY,
        WR_WAIT,
        WR_RDY
    } host_state_e;

    localparam int ADDR_MAX_W = 64;

    function automatic logic [ADDR_MAX_W-1:0] line_idx(input logic [ADDR_MAX_W-1:0] addr,
                                                       input int off, input int idx_w);
        logic [ADDR_MAX_W-1:0] mask;
        mask = (ADDR_MAX_W'(1) << idx_w) - ADDR_MAX_W'(1);
        return (addr >> off) & mask;
    endfunction

    // Any address bit above the line-index field marks the access out of range.
    function automatic logic line_oob(input logic [ADDR_MAX_W-1:0] addr,
                                      input int off, input int idx_w);
        return (addr >> (off + idx_w)) != '0;
    endfunction

endpackage

// File: rtl/host_line_mem.sv
// Line-addressed storage: one synchronous write port, one combinational read port.
module host_line_mem #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 64,
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/host_line_responder.sv
// Host end of the cache-line port: clears its array after reset, then serves line
// reads and writes with fixed wait latencies and requester-driven accept pulses.
module host_line_responder
    import host_if_pkg::*;
#(
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64,
    parameter int DEPTH_LINES   = 64,
    parameter int RD_LATENCY    = 4,
    parameter int WR_LATENCY    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     host_rgo,
    input  logic                     host_re,
    input  logic                     host_wgo,
    input  logic                     host_we,
    input  logic [ADDR_BITCOUNT-1:0] address,
    input  logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out,
    output logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in,
    output logic                     host_init,
    output logic                     host_rd_ready,
    output logic                     host_wr_ready,
    output logic                     err_oob,
    output logic [31:0]              rd_count,
    output logic [31:0]              wr_count
);

    localparam int OFF     = $clog2(CL_SIZE_WIDTH / 8);
    localparam int IDX_W   = $clog2(DEPTH_LINES);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    host_state_e              state_q, state_d;
    logic [IDX_W-1:0]         clr_idx_q, clr_idx_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     oob_q, oob_d;
    logic [CL_SIZE_WIDTH-1:0] rdata_q, rdata_d;
    logic                     init_q, init_d;
    logic                     rd_ready_q, rd_ready_d;
    logic                     wr_ready_q, wr_ready_d;
    logic                     err_oob_q, err_oob_d;
    logic [31:0]              rd_count_q, rd_count_d;
    logic [31:0]              wr_count_q, wr_count_d;

    logic [ADDR_MAX_W-1:0]    addr_ext;
    logic [IDX_W-1:0]         req_idx;
    logic                     req_oob;
    logic                     mem_we;
    logic [IDX_W-1:0]         mem_widx;
    logic [CL_SIZE_WIDTH-1:0] mem_wdata;
    logic [CL_SIZE_WIDTH-1:0] mem_rdata;

    assign addr_ext = ADDR_MAX_W'(address);
    assign req_idx  = IDX_W'(line_idx(addr_ext, OFF, IDX_W));
    assign req_oob  = line_oob(addr_ext, OFF, IDX_W);

    host_line_mem #(
        .WIDTH(CL_SIZE_WIDTH),
        .DEPTH(DEPTH_LINES),
        .IDX_W(IDX_W)
    ) u_mem (
        .clk    (clk),
        .wr_en  (mem_we),
        .wr_idx (mem_widx),
        .wr_data(mem_wdata),
        .rd_idx (idx_q),
        .rd_data(mem_rdata)
    );

    always_comb begin
        state_d    = state_q;
        clr_idx_d  = clr_idx_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        oob_d      = oob_q;
        rdata_d    = rdata_q;
        init_d     = init_q;
        rd_ready_d = rd_ready_q;
        wr_ready_d = wr_ready_q;
        err_oob_d  = err_oob_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        mem_we     = 1'b0;
        mem_widx   = idx_q;
        mem_wdata  = host_data_bus_write_out;

        case (state_q)
            INIT: begin
                mem_we    = 1'b1;
                mem_widx  = clr_idx_q;
                mem_wdata = '0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(DEPTH_LINES - 1)) begin
                    state_d = IDLE;
                    init_d  = 1'b1;
                end
            end
            IDLE: begin
                // Read has priority; a concurrent write stays pending on its held wgo.
                if (host_rgo) begin
                    idx_d     = req_idx;
                    oob_d     = req_oob;
                    err_oob_d = err_oob_q | req_oob;
                    cnt_d     = CNT_W'(RD_LATENCY);
                    state_d   = RD_WAIT;
                end else if (host_wgo) begin
                    idx_d     = req_idx;
                    oob_d     = req_oob;
                    err_oob_d = err_oob_q | req_oob;
                    cnt_d     = CNT_W'(WR_LATENCY);
                    state_d   = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (!host_rgo) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d    = RD_RDY;
                    rd_ready_d = 1'b1;
                    rdata_d    = oob_q ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RD_RDY: begin
                if (host_re) begin
                    rd_count_d = rd_count_q + 32'd1;
                    rd_ready_d = 1'b0;
                    state_d    = IDLE;
                end else if (!host_rgo) begin
                    rd_ready_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            WR_WAIT: begin
                if (!host_wgo) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    state_d    = WR_RDY;
                    wr_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WR_RDY: begin
                if (host_we) begin
                    mem_we     = !oob_q;
                    wr_count_d = wr_count_q + 32'd1;
                    wr_ready_d = 1'b0;
                    state_d    = IDLE;
                end else if (!host_wgo) begin
                    wr_ready_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= INIT;
            clr_idx_q  <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            oob_q      <= 1'b0;
            rdata_q    <= '0;
            init_q     <= 1'b0;
            rd_ready_q <= 1'b0;
            wr_ready_q <= 1'b0;
            err_oob_q  <= 1'b0;
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_idx_q  <= clr_idx_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            oob_q      <= oob_d;
            rdata_q    <= rdata_d;
            init_q     <= init_d;
            rd_ready_q <= rd_ready_d;
            wr_ready_q <= wr_ready_d;
            err_oob_q  <= err_oob_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign host_data_bus_read_in = rdata_q;
    assign host_init             = init_q;
    assign host_rd_ready         = rd_ready_q;
    assign host_wr_ready         = wr_ready_q;
    assign err_oob               = err_oob_q;
    assign rd_count              = rd_count_q;
    assign wr_count              = wr_count_q;

endmodule

// File: tb/tb_host_line_responder.sv
// Bench for host_line_responder: drivers issue requests and queue expected read lines;
// a monitor compares the read bus on every accepted read.
module tb_host_line_responder;

    localparam int W     = 512;
    localparam int AW    = 64;
    localparam int DEPTH = 64;
    localparam int RL    = 4;
    localparam int WL    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          host_rgo = 1'b0;
    logic          host_re = 1'b0;
    logic          host_wgo = 1'b0;
    logic          host_we = 1'b0;
    logic [AW-1:0] address = '0;
    logic [W-1:0]  host_data_bus_write_out = '0;
    logic [W-1:0]  host_data_bus_read_in;
    logic          host_init;
    logic          host_rd_ready;
    logic          host_wr_ready;
    logic          err_oob;
    logic [31:0]   rd_count;
    logic [31:0]   wr_count;

    int total = 0;
    int bad   = 0;
    int n_rd  = 0;
    int n_wr  = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_mem [DEPTH];

    always #5 clk = ~clk;

    host_line_responder #(
        .CL_SIZE_WIDTH(W),
        .ADDR_BITCOUNT(AW),
        .DEPTH_LINES  (DEPTH),
        .RD_LATENCY   (RL),
        .WR_LATENCY   (WL)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .host_rgo               (host_rgo),
        .host_re                (host_re),
        .host_wgo               (host_wgo),
        .host_we                (host_we),
        .address                (address),
        .host_data_bus_write_out(host_data_bus_write_out),
        .host_data_bus_read_in  (host_data_bus_read_in),
        .host_init              (host_init),
        .host_rd_ready          (host_rd_ready),
        .host_wr_ready          (host_wr_ready),
        .err_oob                (err_oob),
        .rd_count               (rd_count),
        .wr_count               (wr_count)
    );

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    // 64-byte lines, 64 lines: index is address[11:6], anything above bit 11 is out of range.
    function automatic logic [5:0] f_idx(input logic [AW-1:0] a);
        return a[11:6];
    endfunction

    function automatic logic f_oob(input logic [AW-1:0] a);
        return |a[AW-1:12];
    endfunction

    function automatic logic [W-1:0] exp_line(input logic [AW-1:0] a);
        return f_oob(a) ? '0 : model_mem[f_idx(a)];
    endfunction

    function automatic logic [W-1:0] rand_line();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    always @(negedge clk) begin
        #1;
        if (rst_n && host_rd_ready && host_re) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected: got %0h with no queued expectation", host_data_bus_read_in);
            end else begin
                check("rd_data", host_data_bus_read_in, exp_q.pop_front());
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_init",     W'(host_init), '0);
        check("rst_rd_ready", W'(host_rd_ready), '0);
        check("rst_wr_ready", W'(host_wr_ready), '0);
        check("rst_err_oob",  W'(err_oob), '0);
        check("rst_rd_count", W'(rd_count), '0);
        check("rst_wr_count", W'(wr_count), '0);
        check("rst_rdata",    host_data_bus_read_in, '0);
    endtask

    // Call with rst_n just released at a negedge; rgo may be held to show it is ignored.
    task automatic wait_init();
        int  k;
        bit  any_rdy;
        k = 0;
        any_rdy = 1'b0;
        while (!host_init && k < 200) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (!host_init && (host_rd_ready || host_wr_ready)) any_rdy = 1'b1;
        end
        check("init_cycles", W'(k), W'(DEPTH));
        check("init_no_ready", W'(any_rdy), '0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input logic [W-1:0] expv);
        int k;
        bit seen;
        address  = a;
        host_rgo = 1'b1;
        exp_q.push_back(expv);
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (host_rd_ready) seen = 1'b1;
        end
        check("rd_latency", W'(k), W'(RL + 1));
        if (seen) begin
            host_re = 1'b1;
            @(posedge clk);
            #1;
            host_re  = 1'b0;
            host_rgo = 1'b0;
            n_rd++;
        end else begin
            host_rgo = 1'b0;
            exp_q.delete(exp_q.size() - 1);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
        int k;
        bit seen;
        address                 = a;
        host_data_bus_write_out = d;
        host_wgo                = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (host_wr_ready) seen = 1'b1;
        end
        check("wr_latency", W'(k), W'(WL + 1));
        if (seen) begin
            host_we = 1'b1;
            @(posedge clk);
            #1;
            host_we  = 1'b0;
            host_wgo = 1'b0;
            n_wr++;
            if (!f_oob(a)) model_mem[f_idx(a)] = d;
        end else begin
            host_wgo = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [W-1:0]  beef;
        logic [W-1:0]  dpri;
        logic [AW-1:0] a;
        int            k;
        bit            seen;

        beef = {16{32'hDEADBEEF}};
        dpri = {16{32'h0BADF00D}};
        clear_model();

        // Power-up reset; hold a read request across the clear to show INIT ignores it.
        rst_n = 1'b0;
        #23;
        check_reset_outputs();
        address  = 64'h140;
        host_rgo = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        do_read(64'h140, '0);

        // Directed write then read of line 5, plus offset alias inside the line.
        do_write(64'h140, beef);
        do_read(64'h140, beef);
        check("rd_count_dir", W'(rd_count), W'(32'd2));
        check("wr_count_dir", W'(wr_count), W'(32'd1));
        do_read(64'h17F, beef);

        // Out-of-range read returns zero and sets the sticky error; oob write is dropped.
        check("err_oob_before", W'(err_oob), '0);
        do_read(64'h1000, '0);
        check("err_oob_after", W'(err_oob), W'(1'b1));
        do_write(64'h1040, {W{1'b1}});
        do_read(64'h40, '0);
        check("err_oob_sticky", W'(err_oob), W'(1'b1));

        // rgo and wgo together: read sees old line 8 content, write follows.
        host_data_bus_write_out = dpri;
        host_wgo = 1'b1;
        do_read(64'h200, '0);
        check("pri_wr_not_ready", W'(host_wr_ready), '0);
        do_write(64'h200, dpri);
        do_read(64'h200, dpri);

        // Abort: drop rgo two cycles into RD_WAIT.
        address  = 64'h140;
        host_rgo = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        host_rgo = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("abort_rd_ready", W'(host_rd_ready), '0);
        check("abort_rd_count", W'(rd_count), W'(n_rd));
        do_read(64'h140, beef);

        // Random traffic against the reference model.
        for (int i = 0; i < 40; i++) begin
            a = (64'($urandom_range(0, DEPTH - 1)) << 6) | 64'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | (64'h1000 << $urandom_range(0, 20));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 1) do_read(a, exp_line(a));
            else do_write(a, rand_line());
        end
        check("stress_rd_count", W'(rd_count), W'(n_rd));
        check("stress_wr_count", W'(wr_count), W'(n_wr));

        // Reset while a write waits for its accept.
        address                 = 64'h140;
        host_data_bus_write_out = {W{1'b1}};
        host_wgo                = 1'b1;
        k = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            if (host_wr_ready) seen = 1'b1;
        end
        check("midrst_wr_ready", W'(seen), W'(1'b1));
        rst_n = 1'b0;
        #1;
        host_wgo = 1'b0;
        check_reset_outputs();
        clear_model();
        n_rd = 0;
        n_wr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_init();
        do_read(64'h140, '0);
        check("midrst_rd_count", W'(rd_count), W'(32'd1));
        check("midrst_wr_count", W'(wr_count), '0);

        repeat (3) @(posedge clk);
        #2;
        check("queue_drained", W'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
